// File: rtl/oled_spi_decoder.sv
// oled_spi_decoder: turns the SSD1306-style serial stream into framebuffer writes and display-control registers.
module oled_spi_decoder #(
    parameter int IDLE_TIMEOUT = 1024,
    parameter int TIMEOUT_W    = 11
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       oled_clk,
    input  logic       oled_data,
    input  logic       oled_dc,
    output logic       fb_we,
    output logic [9:0] fb_addr,
    output logic [7:0] fb_data,
    output logic       frame_done,
    output logic       display_on,
    output logic       invert,
    output logic [7:0] contrast
);
    localparam logic [TIMEOUT_W-1:0] IDLE_MAX = TIMEOUT_W'(IDLE_TIMEOUT);
    typedef enum logic [1:0] {IDLE, ARG1, ARG2} state_t;
    state_t state, state_n;
    logic clk_m, clk_s, clk_p, data_m, data_s, dc_m, dc_s;
    logic [7:0] shift, rx_byte, cmd;
    logic [2:0] bit_cnt, page, page_start, page_end;
    logic [6:0] col, col_start, col_end;
    logic [TIMEOUT_W-1:0] idle_cnt;
    logic rx_valid, rx_dc, rise, takes_arg;
    assign rise = clk_s & ~clk_p;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            {clk_m, clk_s, clk_p, data_m, data_s, dc_m, dc_s} <= '0;
            shift    <= '0;
            rx_byte  <= '0;
            rx_dc    <= 1'b0;
            rx_valid <= 1'b0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
        end else begin
            {clk_p, clk_s, clk_m} <= {clk_s, clk_m, oled_clk};
            {data_s, data_m}      <= {data_m, oled_data};
            {dc_s, dc_m}          <= {dc_m, oled_dc};
            rx_valid <= 1'b0;
            if (rise) begin
                shift    <= {shift[6:0], data_s};
                bit_cnt  <= bit_cnt + 3'd1;
                idle_cnt <= '0;
                if (bit_cnt == 3'd7) begin
                    rx_valid <= 1'b1;
                    rx_byte  <= {shift[6:0], data_s};
                    rx_dc    <= dc_s;
                end
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end else if (bit_cnt != 3'd0) begin
                bit_cnt <= '0;
            end
        end
    end
    always_comb begin
        takes_arg = rx_byte inside {8'h21, 8'h22, 8'h81, 8'h20, 8'h8D, 8'hA8,
                                    8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB};
        state_n = state;
        if (rx_valid) begin
            if (rx_dc)
                state_n = IDLE;
            else if (state == IDLE)
                state_n = takes_arg ? ARG1 : IDLE;
            else if (state == ARG1)
                state_n = (cmd == 8'h21 || cmd == 8'h22) ? ARG2 : IDLE;
            else
                state_n = IDLE;
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            frame_done <= 1'b0;
            display_on <= 1'b0;
            invert     <= 1'b0;
            contrast   <= 8'h7F;
            cmd        <= '0;
            col        <= '0;
            col_start  <= '0;
            col_end    <= 7'd127;
            page       <= '0;
            page_start <= '0;
            page_end   <= 3'd7;
        end else begin
            fb_we      <= 1'b0;
            frame_done <= 1'b0;
            if (rx_valid && rx_dc) begin
                fb_we   <= 1'b1;
                fb_data <= rx_byte;
                fb_addr <= {page, col};
                // start > end windows simply wrap at the field width
                if (col != col_end) begin
                    col <= col + 7'd1;
                end else begin
                    col <= col_start;
                    if (page != page_end) begin
                        page <= page + 3'd1;
                    end else begin
                        page       <= page_start;
                        frame_done <= 1'b1;
                    end
                end
            end else if (rx_valid) begin
                case (state)
                    IDLE: begin
                        cmd <= rx_byte;
                        if (rx_byte[7:1] == 7'h57) display_on <= rx_byte[0];
                        if (rx_byte[7:1] == 7'h53) invert <= rx_byte[0];
                    end
                    ARG1: begin
                        if (cmd == 8'h21) col_start <= rx_byte[6:0];
                        if (cmd == 8'h22) page_start <= rx_byte[2:0];
                        if (cmd == 8'h81) contrast <= rx_byte;
                    end
                    ARG2: begin
                        if (cmd == 8'h21) begin
                            col_end <= rx_byte[6:0];
                            col     <= col_start;
                        end
                        if (cmd == 8'h22) begin
                            page_end <= rx_byte[2:0];
                            page     <= page_start;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
